// File: rtl/stopwatch_gen.sv
// BCD stopwatch time base: MM:SS (optionally HH:MM:SS) with prescaled tick, speed select,
// up/down count with wrap or hold-at-limit, minute adjust while stopped and lap capture.
//
// state     | meaning
// S_STOPPED | prescaler held at 0, minute adjust allowed
// S_RUNNING | prescaler counts, Q steps on every tick
// S_DONE    | limit reached with WRAP=0, Q frozen, minute adjust allowed
module stopwatch_gen #(
  parameter int TICK_DIV     = 50000000,
  parameter int MAX_SPEED    = 3,
  parameter int MIN_TENS_MAX = 5,
  parameter int HOURS_EN     = 0,
  parameter int WRAP         = 1,
  localparam int NDIG = 4 + 2 * HOURS_EN,
  localparam int QW   = 4 * NDIG,
  localparam int SW   = (MAX_SPEED > 0) ? $clog2(MAX_SPEED + 1) : 1
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          ON_OFF,
  input  logic          REVERSE,
  input  logic          SPEED_UP,
  input  logic          SPEED_DOWN,
  input  logic          ADD,
  input  logic          SUBTRACT,
  input  logic          LAP,
  output logic [QW-1:0] Q,
  output logic [QW-1:0] LAP_Q,
  output logic [SW-1:0] SPEED,
  output logic          TICK,
  output logic          DONE
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [SW-1:0] SPEED_MAX = SW'(MAX_SPEED);
  localparam bit HOLD = (WRAP == 0);

  typedef enum logic [1:0] {S_STOPPED, S_RUNNING, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_last;
  logic [4:0]    btn_r;
  logic [4:0]    btn_p;
  logic [4:0]    pulse;
  logic [SW-1:0] speed_nx;
  logic          tick;
  logic          tick_lim;
  logic          add_sat;
  logic          sub_sat;
  logic          do_add;
  logic          do_sub;
  logic [QW-1:0] q_tick;
  logic [QW-1:0] q_add;
  logic [QW-1:0] q_sub;

  function automatic logic [3:0] dmax(input int k);
    case (k)
      1:       dmax = 4'd5;
      3:       dmax = 4'(MIN_TENS_MAX);
      default: dmax = 4'd9;
    endcase
  endfunction

  // Ripple +/-1 starting at digit lo; the MSB of the result is the carry/borrow out,
  // which is high exactly when digits lo and up are all at the limit for that direction.
  function automatic logic [QW:0] bcd_step(input logic [QW-1:0] q, input logic down,
                                           input int lo);
    logic          c;
    logic [QW-1:0] r;
    r = q;
    c = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (k >= lo) begin
        if (c) begin
          if (down)
            r[4*k +: 4] = (q[4*k +: 4] == 4'd0) ? dmax(k) : q[4*k +: 4] - 4'd1;
          else
            r[4*k +: 4] = (q[4*k +: 4] == dmax(k)) ? 4'd0 : q[4*k +: 4] + 4'd1;
        end
        c = c & (down ? (q[4*k +: 4] == 4'd0) : (q[4*k +: 4] == dmax(k)));
      end
    end
    return {c, r};
  endfunction

  assign {tick_lim, q_tick} = bcd_step(Q, REVERSE, 0);
  assign {add_sat, q_add}   = bcd_step(Q, 1'b0, 2);
  assign {sub_sat, q_sub}   = bcd_step(Q, 1'b1, 2);

  assign pulse      = btn_r & ~btn_p;
  assign do_add     = pulse[2] & ~pulse[3] & ~add_sat;
  assign do_sub     = pulse[3] & ~pulse[2] & ~sub_sat;
  assign presc_last = PW'((TICK_DIV >> SPEED) - 1);
  assign tick       = (state == S_RUNNING) && (presc == presc_last);
  assign TICK       = tick;

  always_comb begin
    speed_nx = SPEED;
    if (pulse[0] && !pulse[1] && SPEED != SPEED_MAX)
      speed_nx = SPEED + SW'(1);
    else if (pulse[1] && !pulse[0] && SPEED != '0)
      speed_nx = SPEED - SW'(1);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= S_STOPPED;
      presc <= '0;
      btn_r <= '0;
      btn_p <= '0;
      Q     <= '0;
      LAP_Q <= '0;
      SPEED <= '0;
      DONE  <= 1'b0;
    end else begin
      btn_r <= {LAP, SUBTRACT, ADD, SPEED_DOWN, SPEED_UP};
      btn_p <= btn_r;
      SPEED <= speed_nx;
      if (pulse[4])
        LAP_Q <= Q;
      // A speed change restarts the period so the new divisor never starts mid-count.
      if (state == S_RUNNING && ON_OFF && !tick && speed_nx == SPEED)
        presc <= presc + PW'(1);
      else
        presc <= '0;
      case (state)
        S_STOPPED: begin
          if (do_add)      Q <= q_add;
          else if (do_sub) Q <= q_sub;
          if (ON_OFF) state <= S_RUNNING;
        end
        S_RUNNING: begin
          if (tick && tick_lim && HOLD) begin
            state <= S_DONE;
            DONE  <= 1'b1;
          end else begin
            if (tick)    Q <= q_tick;
            if (!ON_OFF) state <= S_STOPPED;
          end
        end
        S_DONE: begin
          if (do_add)      Q <= q_add;
          else if (do_sub) Q <= q_sub;
          if (!ON_OFF) begin
            state <= S_STOPPED;
            DONE  <= 1'b0;
          end
        end
        default: begin
          state <= S_STOPPED;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_gen.sv
// Three stopwatch_gen variants (wrap MM:SS, hold MM:SS, wrap HH:MM:SS) on shared stimulus,
// compared every cycle against an integer-seconds model, plus directed literal checks.
module tb_stopwatch_gen;

  localparam int ST_STOP = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       ON_OFF = 1'b0;
  logic       REVERSE = 1'b0;
  logic [4:0] btn = '0;  // {LAP, SUBTRACT, ADD, SPEED_DOWN, SPEED_UP}
  logic       SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP;

  assign SPEED_UP   = btn[0];
  assign SPEED_DOWN = btn[1];
  assign ADD        = btn[2];
  assign SUBTRACT   = btn[3];
  assign LAP        = btn[4];

  logic [15:0] q_a, lq_a, q_b, lq_b;
  logic [23:0] q_c, lq_c;
  logic [1:0]  sp_a, sp_b, sp_c;
  logic        tk_a, tk_b, tk_c, dn_a, dn_b, dn_c;

  always #5 clk = ~clk;

  stopwatch_gen #(.TICK_DIV(8), .MAX_SPEED(3), .MIN_TENS_MAX(5), .HOURS_EN(0), .WRAP(1)) u_a (
    .clk(clk), .RESET(RESET), .ON_OFF(ON_OFF), .REVERSE(REVERSE), .SPEED_UP(SPEED_UP),
    .SPEED_DOWN(SPEED_DOWN), .ADD(ADD), .SUBTRACT(SUBTRACT), .LAP(LAP),
    .Q(q_a), .LAP_Q(lq_a), .SPEED(sp_a), .TICK(tk_a), .DONE(dn_a));

  stopwatch_gen #(.TICK_DIV(8), .MAX_SPEED(3), .MIN_TENS_MAX(5), .HOURS_EN(0), .WRAP(0)) u_b (
    .clk(clk), .RESET(RESET), .ON_OFF(ON_OFF), .REVERSE(REVERSE), .SPEED_UP(SPEED_UP),
    .SPEED_DOWN(SPEED_DOWN), .ADD(ADD), .SUBTRACT(SUBTRACT), .LAP(LAP),
    .Q(q_b), .LAP_Q(lq_b), .SPEED(sp_b), .TICK(tk_b), .DONE(dn_b));

  stopwatch_gen #(.TICK_DIV(8), .MAX_SPEED(3), .MIN_TENS_MAX(5), .HOURS_EN(1), .WRAP(1)) u_c (
    .clk(clk), .RESET(RESET), .ON_OFF(ON_OFF), .REVERSE(REVERSE), .SPEED_UP(SPEED_UP),
    .SPEED_DOWN(SPEED_DOWN), .ADD(ADD), .SUBTRACT(SUBTRACT), .LAP(LAP),
    .Q(q_c), .LAP_Q(lq_c), .SPEED(sp_c), .TICK(tk_c), .DONE(dn_c));

  int errors = 0;
  int checks = 0;

  // Model: time held as total seconds modulo the full range of each variant.
  int  m_v[3], m_lap[3], m_st[3], m_pre[3], m_spd[3];
  bit  m_wrap[3] = '{1'b1, 1'b0, 1'b1};
  int  m_n[3]    = '{3600, 3600, 360000};
  logic [4:0] m_r = '0, m_p = '0, pul_m;
  int  per_m, nspd_m;
  bit  tk_m, hold_m;

  function automatic logic [23:0] bcd(input int v);
    int s, m, h;
    s = v % 60;
    m = (v / 60) % 60;
    h = v / 3600;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_lap[i] = 0; m_st[i] = ST_STOP; m_pre[i] = 0; m_spd[i] = 0;
      end
      m_r = '0;
      m_p = '0;
    end else begin
      pul_m = m_r & ~m_p;
      for (int i = 0; i < 3; i++) begin
        per_m  = 8 >> m_spd[i];
        tk_m   = (m_st[i] == ST_RUN) && (m_pre[i] == per_m - 1);
        nspd_m = m_spd[i];
        if (pul_m[0] && !pul_m[1])      nspd_m = (m_spd[i] < 3) ? m_spd[i] + 1 : 3;
        else if (pul_m[1] && !pul_m[0]) nspd_m = (m_spd[i] > 0) ? m_spd[i] - 1 : 0;
        if (pul_m[4]) m_lap[i] = m_v[i];
        hold_m = tk_m && !m_wrap[i] && (REVERSE ? (m_v[i] == 0) : (m_v[i] == m_n[i] - 1));
        if (tk_m && !hold_m)
          m_v[i] = REVERSE ? (m_v[i] + m_n[i] - 1) % m_n[i] : (m_v[i] + 1) % m_n[i];
        if (m_st[i] != ST_RUN) begin
          if (pul_m[2] && !pul_m[3] && m_v[i] + 60 < m_n[i]) m_v[i] += 60;
          else if (pul_m[3] && !pul_m[2] && m_v[i] >= 60)   m_v[i] -= 60;
        end
        m_pre[i] = (m_st[i] == ST_RUN && ON_OFF && !tk_m && nspd_m == m_spd[i]) ? m_pre[i] + 1 : 0;
        case (m_st[i])
          ST_STOP: if (ON_OFF) m_st[i] = ST_RUN;
          ST_RUN:  if (hold_m) m_st[i] = ST_DONE; else if (!ON_OFF) m_st[i] = ST_STOP;
          default: if (!ON_OFF) m_st[i] = ST_STOP;
        endcase
        m_spd[i] = nspd_m;
      end
      m_p = m_r;
      m_r = btn;
    end
  end

  task automatic cmp_inst(input int i, input string nm, input logic [23:0] q, input logic [23:0] lq,
                          input logic [1:0] sp, input logic tk, input logic dn);
    chk({nm, ".Q"},     32'(q),  32'(bcd(m_v[i])));
    chk({nm, ".LAP_Q"}, 32'(lq), 32'(bcd(m_lap[i])));
    chk({nm, ".SPEED"}, 32'(sp), 32'(m_spd[i]));
    chk({nm, ".TICK"},  32'(tk), 32'(m_st[i] == ST_RUN && m_pre[i] == (8 >> m_spd[i]) - 1));
    chk({nm, ".DONE"},  32'(dn), 32'(m_st[i] == ST_DONE));
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      cmp_inst(0, "a", 24'(q_a), 24'(lq_a), sp_a, tk_a, dn_a);
      cmp_inst(1, "b", 24'(q_b), 24'(lq_b), sp_b, tk_b, dn_b);
      cmp_inst(2, "c", q_c, lq_c, sp_c, tk_c, dn_c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(1);
    btn[b] = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    RESET = 1'b1; ON_OFF = 1'b0; REVERSE = 1'b0; btn = '0;
    cyc(2);
    RESET = 1'b0;
    cyc(1);
  endtask

  task automatic wait_v(input int i, input int target, input int limit, input string nm);
    int n;
    n = 0;
    while (m_v[i] != target && n < limit) begin
      cyc(1);
      n++;
    end
    chk({nm, ".reach"}, 32'(m_v[i]), 32'(target));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ntk, first;
    cyc(3);
    chk("rst.Q", 32'(q_a), 0);
    chk("rst.LAP_Q", 32'(lq_a), 0);
    chk("rst.SPEED", 32'(sp_a), 0);
    chk("rst.TICK", 32'(tk_a), 0);
    chk("rst.DONE", 32'(dn_b), 0);
    RESET = 1'b0;
    cyc(1);

    // Speed 0: tick every 8 cycles, ten ticks in 80 running cycles
    ON_OFF = 1'b1;
    ntk = 0;
    first = -1;
    for (int c = 1; c <= 81; c++) begin
      cyc(1);
      if (tk_a) begin
        ntk++;
        if (first < 0) first = c;
      end
    end
    chk("t1.ticks", 32'(ntk), 10);
    chk("t1.first", 32'(first), 8);
    chk("t1.Q", 32'(q_a), 32'h0010);
    chk("t1.Qc", 32'(q_c), 32'h000010);
    ON_OFF = 1'b0;
    cyc(2);

    // Minute preload, count down, wrap from zero
    do_reset();
    repeat (3) press(2);
    chk("t2.add", 32'(q_a), 32'h0300);
    REVERSE = 1'b1;
    ON_OFF = 1'b1;
    cyc(8);
    chk("t2.tick", 32'(tk_a), 1);
    ON_OFF = 1'b0;
    cyc(1);
    chk("t2.down", 32'(q_a), 32'h0259);
    repeat (3) press(0);
    chk("t2.speed", 32'(sp_a), 3);
    ON_OFF = 1'b1;
    wait_v(0, 1, 400, "t2");
    ON_OFF = 1'b0;
    cyc(1);
    chk("t2.zero", 32'(q_a), 0);
    ON_OFF = 1'b1;
    cyc(1);
    ON_OFF = 1'b0;
    cyc(1);
    chk("t2.wrap", 32'(q_a), 32'h5959);
    chk("t2.wrapc", 32'(q_c), 32'h995959);
    chk("t2.holdb", 32'(q_b), 0);
    chk("t2.doneb", 32'(dn_b), 1);
    cyc(1);
    chk("t2.doneb_off", 32'(dn_b), 0);

    // Count up to the limit: hold variant freezes and flags DONE, hours variant rolls over
    do_reset();
    repeat (3) press(0);
    repeat (59) press(2);
    chk("t3.add59", 32'(q_a), 32'h5900);
    ON_OFF = 1'b1;
    wait_v(1, 3599, 200, "t3");
    cyc(1);
    chk("t3.holdQ", 32'(q_b), 32'h5959);
    chk("t3.done", 32'(dn_b), 1);
    chk("t3.hours", 32'(q_c), 32'h010000);
    chk("t3.wrapa", 32'(q_a), 0);
    ON_OFF = 1'b0;
    cyc(1);
    chk("t3.done_off", 32'(dn_b), 0);
    press(2);
    chk("t3.addsat", 32'(q_b), 32'h5959);

    // Speed saturation and simultaneous up/down
    do_reset();
    press(3);
    chk("t4.subsat", 32'(q_a), 0);
    repeat (5) press(0);
    chk("t4.smax", 32'(sp_a), 3);
    press(1);
    chk("t4.sdown", 32'(sp_a), 2);
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    cyc(1);
    btn = '0;
    cyc(3);
    chk("t4.both", 32'(sp_a), 2);
    repeat (4) press(1);
    chk("t4.smin", 32'(sp_a), 0);
    repeat (3) press(0);
    ON_OFF = 1'b1;
    cyc(1);
    ntk = 0;
    for (int c = 0; c < 6; c++) begin
      if (tk_a) ntk++;
      cyc(1);
    end
    chk("t4.period1", 32'(ntk), 6);
    ON_OFF = 1'b0;
    cyc(2);

    // Lap coincident with tick; adjust ignored while running
    do_reset();
    press(2);
    repeat (3) press(0);
    ON_OFF = 1'b1;
    wait_v(0, 82, 100, "t5");
    btn[4] = 1'b1;
    cyc(1);
    btn[4] = 1'b0;
    cyc(1);
    chk("t5.lap", 32'(lq_a), 32'h0123);
    chk("t5.Q", 32'(q_a), 32'h0124);
    ON_OFF = 1'b0;
    cyc(1);
    chk("t5.stop", 32'(q_a), 32'h0125);
    repeat (3) press(1);
    ON_OFF = 1'b1;
    btn[2] = 1'b1;
    cyc(1);
    btn[2] = 1'b0;
    cyc(1);
    ON_OFF = 1'b0;
    cyc(2);
    chk("t5.addrun", 32'(q_a), 32'h0125);

    // Asynchronous reset mid-run
    do_reset();
    repeat (2) press(0);
    ON_OFF = 1'b1;
    wait_v(0, 20, 200, "t6a");
    press(4);
    wait_v(0, 42, 200, "t6b");
    chk("t6.pre", 32'(q_a), 32'h0042);
    RESET = 1'b1;
    ON_OFF = 1'b0;
    #1;
    chk("t6.Q", 32'(q_a), 0);
    chk("t6.LAP_Q", 32'(lq_a), 0);
    chk("t6.SPEED", 32'(sp_a), 0);
    chk("t6.TICK", 32'(tk_a), 0);
    chk("t6.Qc", 32'(q_c), 0);
    cyc(2);
    RESET = 1'b0;
    cyc(1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) ON_OFF = ~ON_OFF;
      if ($urandom_range(0, 59) == 0) REVERSE = ~REVERSE;
      for (int b = 0; b < 5; b++) btn[b] = ($urandom_range(0, 7) == 0);
      RESET = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    RESET = 1'b0;
    btn = '0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_gen.md
Name: stopwatch_gen

Overview:
Parametrised successor to the fixed MM:SS stopwatch. Provides a BCD time counter of configurable depth (optional hours digits) with:
- an internal tick prescaler and run-time speed selection
- up/down counting, with a selectable wrap or stop-at-limit policy and a DONE state
- minute adjust while stopped
- a lap-capture register
Sits between the debounced front-panel buttons and the 7-segment display driver.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick at speed 0; power of two, >= 2^MAX_SPEED.
MAX_SPEED, 3, highest speed index; tick period = TICK_DIV >> speed.
MIN_TENS_MAX, 5, maximum value of minutes-tens digit (1..9).
HOURS_EN, 0, 1 adds two BCD hours digits (00-99) above minutes.
WRAP, 1, 1 = wrap at limit; 0 = hold at limit and enter DONE.
NDIG (derived), 4+2*HOURS_EN, number of BCD digits.

Ports:
clk  in  1  system clock
RESET  in  1  asynchronous active-high reset
ON_OFF  in  1  level run enable
REVERSE  in  1  level; 1 = count down
SPEED_UP  in  1  button, rising-edge sensitive
SPEED_DOWN  in  1  button, rising-edge sensitive
ADD  in  1  button, rising-edge sensitive; +1 minute
SUBTRACT  in  1  button, rising-edge sensitive; -1 minute
LAP  in  1  button, rising-edge sensitive; capture Q
Q  out  4*NDIG  BCD digits; [3:0] sec units (0-9), [7:4] sec tens (0-5), [11:8] min units (0-9), [15:12] min tens (0-MIN_TENS_MAX), then hours units, hours tens (0-9 each)
LAP_Q  out  4*NDIG  last captured Q
SPEED  out  clog2(MAX_SPEED+1)  current speed index
TICK  out  1  one-cycle pulse on every count tick
DONE  out  1  high while in DONE state

Behaviour:
- Reset (async, RESET=1):
  - Q=0, LAP_Q=0, SPEED=0, TICK=0, DONE=0.
  - Prescaler=0, state=STOPPED, edge-detect registers=0.
- Edge detect:
  - Each button is registered once; the pulse is input & ~prev. Action occurs in the cycle after the rising edge is registered.
  - Simultaneous SPEED_UP/SPEED_DOWN pulses: both ignored.
  - Simultaneous ADD/SUBTRACT pulses: both ignored.
- State machine (STOPPED, RUNNING, DONE):
  - STOPPED->RUNNING when ON_OFF=1.
  - RUNNING->STOPPED when ON_OFF=0.
  - RUNNING->DONE when WRAP=0 and a tick arrives with Q at limit. The limit is all-max when counting up, all-zero when counting down.
  - DONE->STOPPED when ON_OFF=0. DONE=1 only in DONE.
- Prescaler:
  - Counts only in RUNNING; otherwise held at 0.
  - TICK=1 when prescaler = (TICK_DIV>>SPEED)-1; the prescaler returns to 0 in the same cycle.
  - Any SPEED change clears the prescaler.
  - SPEED saturates at 0 and at MAX_SPEED.
- Count on TICK:
  - Digit 0 increments (REVERSE=0) or decrements (REVERSE=1).
  - Digit k changes only if all lower digits are at max (up) or 0 (down), i.e. ripple carry/borrow, same cycle.
  - REVERSE is sampled at the tick.
  - At the limit with WRAP=1: all-max+1 -> all 0; all-0 -1 -> all-max.
  - At the limit with WRAP=0: Q unchanged, enter DONE.
- ADD/SUBTRACT:
  - Honoured only in STOPPED or DONE; ignored in RUNNING.
  - Adds or subtracts 1 at minutes-units, with carry/borrow into higher digits. Seconds are untouched.
  - Saturating: ADD when the minutes-and-above field is at max leaves Q unchanged; SUBTRACT when minutes-and-above are all 0 leaves Q unchanged.
  - An adjust in DONE leaves the state at DONE.
- LAP:
  - LAP_Q <= Q in any state.
  - If LAP and TICK coincide, LAP_Q takes Q before the tick update.
- All digits are always valid BCD within their range. No illegal codes are reachable.

Test Plan:
1. TICK_DIV=8, MAX_SPEED=3, WRAP=1; RESET, then ON_OFF=1 for 80 cycles -> TICK every 8 cycles, Q=16'h0010 after 10 ticks.
2. Preload via ADD x3 while stopped -> Q=16'h0300. Run with REVERSE=1 for 1 tick -> Q=16'h0259. At Q=0, one further tick -> Q=16'h5959 (MIN_TENS_MAX=5).
3. WRAP=0, REVERSE=0, ADD to 59 minutes, run to 16'h5959, one more tick -> Q holds 16'h5959, DONE=1. ON_OFF=0 -> DONE=0 next cycle.
4. SPEED_UP x5 -> SPEED=3 (saturated), TICK period 1 cycle. SPEED_UP and SPEED_DOWN in the same cycle -> SPEED unchanged. SPEED_DOWN x4 -> SPEED=0.
5. RUNNING with Q=16'h0123, LAP pulse coincident with TICK -> LAP_Q=16'h0123, Q=16'h0124. ADD while RUNNING -> Q unaffected.
6. RESET asserted mid-run at Q=16'h0042, SPEED=2, DONE irrelevant -> all outputs 0 asynchronously before the next clk edge. HOURS_EN=1: from 16'h5959 (hours 00), tick -> Q=24'h010000.
